// File: rtl/mem_stage_hs.sv
// mem_stage_hs: single-entry memory stage between execute and writeback; issues cache
// requests, places store lanes, extends load data and drives forwarding/stall signals.
module mem_stage_hs #(
    parameter int XLEN = 64,
    parameter int RD_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_aluresult,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_mem_active,
    input  logic              in_load,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_store_data,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic [XLEN-1:0]   dc_req_addr,
    output logic              dc_req_write,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [XLEN/8-1:0] dc_req_wstrb,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_aluresult,
    output logic [XLEN-1:0]   out_loaddata,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_misalign,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]   fwd_val,
    output logic              fwd_stall
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_alu, r_sdata, r_loaddata;
    logic [RD_W-1:0] r_rd;
    logic [1:0]      r_size;
    logic            r_mem, r_load, r_uns, r_misalign;
    logic            w_accept, w_mis;
    logic [OW-1:0]   w_off;
    logic [NB-1:0]   w_lanes;
    logic [XLEN-1:0] w_bmask, w_shifted, w_ext;
    logic [SW-1:0]   w_sidx;

    assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept = in_valid & in_ready;
    // Doubleword accesses do not exist on a 32-bit datapath, so they trap as misaligned.
    assign w_mis = (|(in_aluresult[OW-1:0] & OW'((1 << in_size) - 1)))
                 | ((in_size == 2'd3) && (XLEN == 32));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ISSUE: w_next = dc_req_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next = dc_resp_valid ? S_DONE : S_WAIT;
            default: w_next = w_accept ? ((in_mem_active & ~w_mis) ? S_ISSUE : S_DONE)
                            : ((r_state == S_DONE) & out_ready) ? S_IDLE : r_state;
        endcase
    end

    // Lane masks come from the held size; byte offset is the held address low bits.
    assign w_off   = r_alu[OW-1:0];
    assign w_lanes = NB'((1 << (1 << r_size)) - 1);

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < NB; b++) w_bmask[8*b +: 8] = {8{w_lanes[b]}};
    end

    assign w_sidx    = SW'((8 << r_size) - 1);
    assign w_shifted = dc_resp_data >> {w_off, 3'b000};
    assign w_ext     = (w_shifted & w_bmask) | ({XLEN{~r_uns & w_shifted[w_sidx]}} & ~w_bmask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_alu      <= '0;
            r_sdata    <= '0;
            r_loaddata <= '0;
            r_rd       <= '0;
            r_size     <= '0;
            r_mem      <= 1'b0;
            r_load     <= 1'b0;
            r_uns      <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_alu      <= in_aluresult;
                r_sdata    <= in_store_data;
                r_loaddata <= '0;
                r_rd       <= in_rd;
                r_size     <= in_size;
                r_mem      <= in_mem_active;
                r_load     <= in_load;
                r_uns      <= in_unsigned;
                r_misalign <= in_mem_active & w_mis;
            end else if ((r_state == S_WAIT) && dc_resp_valid) begin
                r_loaddata <= r_load ? w_ext : '0;
            end
        end
    end

    assign dc_req_valid  = r_state == S_ISSUE;
    assign dc_req_addr   = {r_alu[XLEN-1:OW], OW'(0)};
    assign dc_req_write  = r_mem & ~r_load;
    assign dc_req_wdata  = (r_sdata & w_bmask) << {w_off, 3'b000};
    assign dc_req_wstrb  = dc_req_write ? NB'(w_lanes << w_off) : '0;
    assign out_valid     = r_state == S_DONE;
    assign out_aluresult = r_alu;
    assign out_loaddata  = r_loaddata;
    assign out_rd        = r_rd;
    assign out_misalign  = r_misalign;
    assign fwd_rd        = (r_state != S_IDLE) ? r_rd : '0;
    assign fwd_val       = (r_mem & r_load & out_valid) ? r_loaddata : r_alu;
    assign fwd_stall     = r_mem & r_load & (|r_rd) & ((r_state == S_ISSUE) | (r_state == S_WAIT));
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: randomized scoreboard bench for mem_stage_hs; expectations come from a
// byte-addressed memory model, the cache side keeps its own memory written by DUT strobes.
module tb_mem_stage_hs;
    localparam int XLEN = 64;
    localparam int RD_W = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid, in_ready, in_mem_active, in_load, in_unsigned;
    logic [63:0]     in_aluresult, in_store_data;
    logic [5:0]      in_rd;
    logic [1:0]      in_size;
    logic            dc_req_valid, dc_req_ready, dc_req_write, dc_resp_valid;
    logic [63:0]     dc_req_addr, dc_req_wdata, dc_resp_data;
    logic [7:0]      dc_req_wstrb;
    logic            out_valid, out_ready, out_misalign, fwd_stall;
    logic [63:0]     out_aluresult, out_loaddata, fwd_val;
    logic [5:0]      out_rd, fwd_rd;

    mem_stage_hs #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluresult(in_aluresult), .in_rd(in_rd),
        .in_mem_active(in_mem_active), .in_load(in_load), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_store_data(in_store_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_write(dc_req_write), .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluresult(out_aluresult),
        .out_loaddata(out_loaddata), .out_rd(out_rd), .out_misalign(out_misalign),
        .fwd_rd(fwd_rd), .fwd_val(fwd_val), .fwd_stall(fwd_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [5:0]  rd;
        logic        ld;
        logic [63:0] data;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        wr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic        stall;
        logic [5:0]  rd;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [7:0]  ref_mem[longint];
    logic [7:0]  cache_mem[longint];
    int          vectors = 0;
    int          errors = 0;
    int          outs = 0;
    int          or_mode = 0;
    int          force_dly = -1;
    int          dly = 0;
    bit          hold_resp = 0;
    bit          squash = 0;
    bit          busy = 0;
    logic        cur_stall = 1'b0;
    logic [63:0] rdata = '0;

    function automatic logic [7:0] init_byte(longint a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] ref_rd(longint a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] cache_rd(longint a);
        return cache_mem.exists(a) ? cache_mem[a] : init_byte(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Presents one instruction, holds it until accepted, and records what must come back.
    task automatic send(input logic [63:0] alu, input logic [5:0] rd, input logic mem,
                        input logic ld, input logic [1:0] sz, input logic uns, input logic [63:0] sd);
        exp_t e;
        req_t r;
        int   n, off, cyc;
        n = 1 << sz;
        off = int'(alu[2:0]);
        e.alu = alu;
        e.rd = rd;
        e.ld = mem & ld;
        e.data = '0;
        e.mis = mem && ((alu % 64'(n)) != 0);
        in_aluresult = alu; in_rd = rd; in_mem_active = mem; in_load = ld;
        in_size = sz; in_unsigned = uns; in_store_data = sd; in_valid = 1'b1;
        cyc = 0;
        #1;
        while (!in_ready && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        if (mem && !e.mis) begin
            r.addr = alu & ~64'h7;
            r.wr = !ld;
            r.strb = '0;
            r.wdata = '0;
            r.stall = ld && (rd != 0);
            r.rd = rd;
            for (int i = 0; i < n; i++) begin
                if (ld) e.data[8*i +: 8] = ref_rd(longint'(alu) + i);
                else begin
                    r.strb[off+i] = 1'b1;
                    r.wdata[8*(off+i) +: 8] = sd[8*i +: 8];
                    ref_mem[longint'(alu) + i] = sd[8*i +: 8];
                end
            end
            if (ld && !uns && n < 8 && e.data[8*n-1]) e.data = e.data | (~64'd0 << (8*n));
            req_q.push_back(r);
        end
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 1000) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Writeback monitor and cache model; both act on the falling edge.
    initial begin
        exp_t e;
        req_t r;
        out_ready = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
        forever begin
            @(negedge clk);
            out_ready = (or_mode == 1) || (or_mode == 0 && $urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                outs++;
                if (exp_q.size() == 0) chk("out_spurious", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_alu", out_aluresult, e.alu);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_loaddata", out_loaddata, e.data);
                    chk("out_misalign", out_misalign, e.mis);
                    chk("fwd_rd_done", fwd_rd, e.rd);
                    chk("fwd_val_done", fwd_val, e.ld ? e.data : e.alu);
                    chk("fwd_stall_done", fwd_stall, 0);
                end
            end
            dc_resp_valid = 1'b0;
            dc_resp_data = {$urandom, $urandom};
            if (busy && !squash) chk("fwd_stall_wait", fwd_stall, cur_stall);
            if (busy && !hold_resp) begin
                if (dly == 0) begin
                    dc_resp_valid = 1'b1;
                    dc_resp_data = rdata;
                    busy = 0;
                end else dly--;
            end
            dc_req_ready = 1'b0;
            if (dc_req_valid && !busy && $urandom_range(0, 2) != 0) begin
                dc_req_ready = 1'b1;
                if (req_q.size() == 0) chk("req_spurious", dc_req_valid, 0);
                else begin
                    r = req_q.pop_front();
                    chk("req_addr", dc_req_addr, r.addr);
                    chk("req_write", dc_req_write, r.wr);
                    chk("req_wstrb", dc_req_wstrb, r.strb);
                    if (r.wr) chk("req_wdata", dc_req_wdata, r.wdata);
                    chk("fwd_stall_issue", fwd_stall, r.stall);
                    chk("fwd_rd_issue", fwd_rd, r.rd);
                    cur_stall = r.stall;
                end
                for (int b = 0; b < 8; b++)
                    if (dc_req_write && dc_req_wstrb[b])
                        cache_mem[longint'(dc_req_addr) + b] = dc_req_wdata[8*b +: 8];
                for (int b = 0; b < 8; b++) rdata[8*b +: 8] = cache_rd(longint'(dc_req_addr) + b);
                busy = 1;
                dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, n0, sz, off, k;
        longint      t0;
        logic [63:0] addr;
        in_valid = 1'b0; in_aluresult = '0; in_rd = '0; in_mem_active = 1'b0; in_load = 1'b0;
        in_size = '0; in_unsigned = 1'b0; in_store_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", dc_req_valid, 0);
        chk("rst_fwd_rd", fwd_rd, 0);
        chk("rst_fwd_val", fwd_val, 0);
        chk("rst_loaddata", out_loaddata, 0);
        @(negedge clk);
        reset = 1'b1;
        or_mode = 1;
        @(negedge clk);

        send(64'h1234, 6'd5, 0, 0, 0, 0, 64'h0);
        #1 chk("nonmem_latency", out_valid, 1);
        drain();

        t0 = $time;
        for (int i = 0; i < 8; i++) send(64'h100 + 64'(i), 6'(i + 1), 0, 0, 0, 0, 64'h0);
        chk("throughput_cycles", 64'(($time - t0) / 10), 8);
        drain();

        for (int a = 0; a < 8; a++) begin
            ref_mem[64'h1000 + a] = 8'h00;
            cache_mem[64'h1000 + a] = 8'h00;
        end
        ref_mem[64'h1003] = 8'h80;
        cache_mem[64'h1003] = 8'h80;
        force_dly = 2;
        send(64'h1003, 6'd3, 1, 1, 2'd0, 0, 64'h0);
        send(64'h1003, 6'd4, 1, 1, 2'd0, 1, 64'h0);
        force_dly = -1;
        send(64'h2006, 6'd0, 1, 0, 2'd1, 0, 64'hBEEF);
        send(64'h3002, 6'd8, 1, 1, 2'd2, 0, 64'h0);
        #1;
        chk("misalign_latency", out_valid, 1);
        chk("misalign_noreq", dc_req_valid, 0);
        drain();

        or_mode = 2;
        @(negedge clk);
        send(64'hABCD, 6'd9, 0, 0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_alu", out_aluresult, 64'hABCD);
            chk("bp_hold_rd", out_rd, 9);
            @(negedge clk);
        end
        #1;
        n0 = outs;
        or_mode = 1;
        repeat (3) @(negedge clk);
        #2 chk("bp_one_handshake", 64'(outs - n0), 1);
        drain();

        hold_resp = 1;
        send(64'h1010, 6'd7, 1, 1, 2'd3, 0, 64'h0);
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            cyc++;
        end while (!busy && cyc < 100);
        squash = 1;
        reset = 1'b0;
        #1;
        chk("rstw_in_ready", in_ready, 1);
        chk("rstw_out_valid", out_valid, 0);
        chk("rstw_req_valid", dc_req_valid, 0);
        chk("rstw_fwd_rd", fwd_rd, 0);
        chk("rstw_fwd_stall", fwd_stall, 0);
        chk("rstw_req_addr", dc_req_addr, 0);
        chk("rstw_out_rd", out_rd, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b1;
        hold_resp = 0;
        repeat (8) begin
            @(negedge clk);
            #1 chk("rstw_no_out", out_valid, 0);
        end
        squash = 0;
        drain();

        or_mode = 0;
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            sz = $urandom_range(0, 3);
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
            addr = 64'h1000 + 64'($urandom_range(0, 3) * 8 + off);
            if (k < 3) send({$urandom, $urandom}, 6'($urandom_range(0, 63)), 0, 1'($urandom_range(0, 1)),
                            2'(sz), 0, {$urandom, $urandom});
            else send(addr, 6'($urandom_range(0, 63)), 1, k < 6, 2'(sz), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        or_mode = 1;
        drain();
        chk("req_q_empty", req_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised memory pipeline stage sitting between execute and writeback, replacing the fixed 64-bit latch-and-forward stage. It accepts one instruction at a time over a valid/ready handshake and issues loads and stores to the data cache over a request/response interface. It extracts, aligns and sign/zero-extends sub-word load data, generates store byte strobes, flags misaligned accesses, and drives the execute-stage forwarding and load-use stall signals.

## Interface
- XLEN, 64, datapath width; legal values are 32 or 64.
- RD_W, 6, destination-register tag width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept this cycle.
- in_aluresult  in  XLEN  ALU result or effective address.
- in_rd  in  RD_W  destination register; 0 means no write.
- in_mem_active  in  1  instruction is a load or store.
- in_load  in  1  1 = load, 0 = store; meaningful only when in_mem_active is 1.
- in_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- in_unsigned  in  1  zero-extend load data instead of sign-extending.
- in_store_data  in  XLEN  rs2 value for stores.
- dc_req_valid / dc_req_ready  out / in  1  cache request handshake.
- dc_req_addr  out  XLEN  request address, with the low log2(XLEN/8) bits cleared.
- dc_req_write  out  1  1 = store.
- dc_req_wdata  out  XLEN  store data shifted to its byte lane.
- dc_req_wstrb  out  XLEN/8  store byte enables; all zero for loads.
- dc_resp_valid  in  1  response or store acknowledge; always accepted.
- dc_resp_data  in  XLEN  full aligned word read.
- out_valid / out_ready  out / in  1  writeback handshake.
- out_aluresult  out  XLEN  held ALU result.
- out_loaddata  out  XLEN  extended load data; 0 for non-loads.
- out_rd  out  RD_W  held destination.
- out_misalign  out  1  access was misaligned or illegal; no cache request was made.
- fwd_rd  out  RD_W  destination of the held instruction; 0 when the stage is empty.
- fwd_val  out  XLEN  value to forward.
- fwd_stall  out  1  held load's value is not yet available.

## Operation
- State machine with four states: IDLE (empty), ISSUE (dc_req_valid high), WAIT (awaiting dc_resp_valid), DONE (out_valid high).
- in_ready = (state == IDLE) | (state == DONE & out_ready). An input handshake latches all in_* fields.
- On acceptance, the next state is chosen as follows:
  - Non-memory instruction: DONE.
  - Memory instruction that is misaligned: DONE with out_misalign = 1. Misaligned means the address is not a multiple of 2^in_size, or in_size = 3 with XLEN = 32.
  - Otherwise: ISSUE.
- ISSUE: dc_req_valid = 1 and all dc_req_* fields are stable. On dc_req_ready, go to WAIT.
- WAIT: on dc_resp_valid, capture the result and go to DONE.
  - Loads: select the lane at byte offset addr[log2(XLEN/8)-1:0], then extend to XLEN per in_unsigned.
  - Stores: out_loaddata = 0.
- DONE: out_valid = 1. On out_ready, either go to IDLE, or accept a new input in the same cycle and take the next state it requires.
- dc_resp_valid outside WAIT is ignored. This covers stale responses after reset.
- Store lane placement:
  - wdata = in_store_data low 2^size bytes shifted left by 8 × offset.
  - wstrb = ((1 << 2^size) − 1) << offset.
- Forwarding:
  - fwd_rd = held rd whenever state ≠ IDLE, otherwise 0.
  - fwd_val = out_loaddata for a load in DONE, otherwise the aluresult.
  - fwd_stall = 1 for a load with rd ≠ 0 in ISSUE or WAIT.

## Timing
- Reset values: state = IDLE, all registered fields = 0, in_ready = 1. Every other output is 0.
- Reset asserted mid-transaction abandons the request immediately. dc_req_valid drops asynchronously, and any later response is discarded.
- Non-memory latency: accepted at edge N, out_valid high after edge N.
- Memory latency:
  - dc_req_valid rises after the accept edge.
  - Response sampled at edge M puts out_valid high after M.
  - Minimum load-to-writeback latency with a zero-wait cache is 3 cycles.
- The cache must not return a response in the same cycle as its request handshake.
- Outputs are registered state except in_ready and the forwarding mux. in_ready depends combinationally on out_ready.
- Simultaneous out_ready and in_valid in DONE gives back-to-back throughput of one per cycle for non-memory instructions.

## Test plan
- Non-memory pass-through: aluresult 0x1234, rd 5, out_ready tied 1 → out_valid one cycle later with out_rd = 5, out_loaddata = 0; a continuous stream sustains 1/cycle.
- Signed byte load:
  - Stimulus: address 0x1003; cache returns 0x0000_0000_8000_0000 after 2 wait cycles.
  - Required response: dc_req_addr = 0x1000, out_loaddata = 0xFFFF_FFFF_FFFF_FF80.
  - Repeating with in_unsigned = 1 gives 0x80.
  - fwd_stall is high until DONE.
- Half store at 0x2006, data 0xBEEF → dc_req_wstrb = 0xC0, dc_req_wdata = 0xBEEF_0000_0000_0000, dc_req_write = 1.
- Misaligned word load at 0x3002 → no dc_req_valid, out_misalign = 1, out_valid high one cycle after accept.
- Backpressure: out_ready low for 4 cycles in DONE → in_ready stays low and outputs stay stable; release yields exactly one out handshake.
- reset pulsed low while in WAIT → all outputs go to 0 and in_ready goes to 1; a later dc_resp_valid produces no out_valid.
